// File: rtl/bank_serial_ctrl.sv
// Serial command front-end for the 128x128 two-port SRAM bank: deserialises chip-select framed commands.
// Write strobe lands 136 cycles after frame start; read data streams out from frame start + 9 + RD_LAT; no backpressure, frames are paced by the host.
module bank_serial_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128,
    parameter int RD_LAT = 1
) (
    input  logic              vsi_clk,
    input  logic              vsi_reset_n,
    input  logic              vsi_inputData,
    input  logic              vsi_chipSelect,
    output logic              vsi_outputData,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] wr_mask,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err
);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, WRITE, RREQ, RWAIT, ROUT, DONE} state_t;

    localparam logic [7:0] HDR_LAST   = 8'(ADDR_W);
    localparam logic [7:0] WDATA_LAST = 8'(ADDR_W + DATA_W);
    localparam logic [7:0] OUT_LAST   = 8'(DATA_W - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(RD_LAT);

    state_t              state, nextState;
    logic                abort;
    logic [7:0]          cnt;
    logic                opReg;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   dataReg;
    logic [DATA_W-1:0]   outShift;
    logic                outBit;
    logic                frameErr;

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) state <= IDLE;
        else              state <= nextState;
    end

    always_comb begin
        nextState = state;
        abort     = 1'b0;
        case (state)
            IDLE:  if (vsi_chipSelect) nextState = HDR;
            HDR:   if (!vsi_chipSelect) abort = 1'b1;
                   else if (cnt == HDR_LAST) nextState = opReg ? WDATA : RREQ;
            WDATA: if (!vsi_chipSelect) abort = 1'b1;
                   else if (cnt == WDATA_LAST) nextState = WRITE;
            // The write is already committed; a low chip-select here still counts as the inter-frame gap.
            WRITE: nextState = vsi_chipSelect ? DONE : IDLE;
            RREQ:  if (!vsi_chipSelect) abort = 1'b1;
                   else nextState = RWAIT;
            RWAIT: if (!vsi_chipSelect) abort = 1'b1;
                   else if (cnt == WAIT_LAST) nextState = ROUT;
            ROUT:  if (!vsi_chipSelect) abort = 1'b1;
                   else if (cnt == OUT_LAST) nextState = DONE;
            DONE:  if (!vsi_chipSelect) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            cnt      <= '0;
            opReg    <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
            outShift <= '0;
            outBit   <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            frameErr <= abort;
            case (state)
                IDLE: if (vsi_chipSelect) begin
                    opReg <= vsi_inputData;
                    cnt   <= 8'd1;
                end
                HDR: if (vsi_chipSelect) begin
                    addrReg <= {addrReg[ADDR_W-2:0], vsi_inputData};
                    cnt     <= cnt + 8'd1;
                end
                WDATA: if (vsi_chipSelect) begin
                    dataReg <= {dataReg[DATA_W-2:0], vsi_inputData};
                    cnt     <= cnt + 8'd1;
                end
                RREQ: cnt <= 8'd1;
                RWAIT: begin
                    if (cnt == WAIT_LAST) begin
                        outBit   <= rd_data[DATA_W-1];
                        outShift <= {rd_data[DATA_W-2:0], 1'b0};
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ROUT: begin
                    outBit   <= (cnt == OUT_LAST) ? 1'b0 : outShift[DATA_W-1];
                    outShift <= {outShift[DATA_W-2:0], 1'b0};
                    cnt      <= cnt + 8'd1;
                end
                default: ;
            endcase
            // Aborted reads discard whatever was captured or in flight.
            if (abort) outBit <= 1'b0;
        end
    end

    assign wr_en          = (state == WRITE);
    assign wr_mask        = {DATA_W{wr_en}};
    assign wr_addr        = wr_en ? addrReg : '0;
    assign wr_data        = wr_en ? dataReg : '0;
    assign rd_en          = (state == RREQ);
    assign rd_addr        = rd_en ? addrReg : '0;
    assign vsi_outputData = outBit;
    assign frame_err      = frameErr;

endmodule

// File: tb/tb_bank_serial_ctrl.sv
// Bench for bank_serial_ctrl: SRAM model plus a cycle-stamped scoreboard of expected strobes and output bits.
module tb_bank_serial_ctrl;
    parameter int RD_LAT = 1;

    localparam logic [127:0] W0 = 128'hDEADBEEF_00000000_CAFEF00D_5A5AA5A5;
    localparam logic [127:0] W1 = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] W2 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    localparam logic [127:0] W3 = 128'h80000000_FFFF0000_12345678_00000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         cs = 1'b0;
    logic         vsi_outputData;
    logic         wr_en, rd_en, frame_err;
    logic [6:0]   wr_addr, rd_addr;
    logic [127:0] wr_data, wr_mask, rd_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {int cyc; logic [6:0] addr; logic [127:0] data;} ev_t;
    typedef struct {int cyc; logic b;} ob_t;
    ev_t expWr[$];
    ev_t expRd[$];
    int  expErr[$];
    ob_t expOut[$];

    logic [127:0] mem [128];
    logic [127:0] p0 = '0;
    logic [127:0] p1 = '0;

    bank_serial_ctrl #(.ADDR_W(7), .DATA_W(128), .RD_LAT(RD_LAT)) dut (
        .vsi_clk(clk), .vsi_reset_n(rst_n), .vsi_inputData(din), .vsi_chipSelect(cs),
        .vsi_outputData(vsi_outputData), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data valid exactly RD_LAT cycles after rd_en, zero otherwise.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        p0 <= rd_en ? mem[rd_addr] : '0;
        p1 <= p0;
    end
    assign rd_data = (RD_LAT == 2) ? p1 : p0;

    always @(negedge clk) begin
        if (wr_en) begin
            tests++;
            if (expWr.size() == 0) begin
                fails++; $display("FAIL wr_unexpected cyc=%0d addr=%h", cyc, wr_addr);
            end else begin
                ev_t e;
                e = expWr.pop_front();
                if (cyc !== e.cyc || wr_addr !== e.addr || wr_data !== e.data || wr_mask !== {128{1'b1}}) begin
                    fails++;
                    $display("FAIL wr_event cyc=%0d addr=%h data=%h mask=%h, want cyc=%0d addr=%h data=%h mask all ones",
                             cyc, wr_addr, wr_data, wr_mask, e.cyc, e.addr, e.data);
                end
            end
        end else if (wr_mask !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            tests++; fails++;
            $display("FAIL wr_idle cyc=%0d mask=%h addr=%h, want zero", cyc, wr_mask, wr_addr);
        end
        if (rd_en) begin
            tests++;
            if (expRd.size() == 0) begin
                fails++; $display("FAIL rd_unexpected cyc=%0d addr=%h", cyc, rd_addr);
            end else begin
                ev_t e;
                e = expRd.pop_front();
                if (cyc !== e.cyc || rd_addr !== e.addr) begin
                    fails++;
                    $display("FAIL rd_event cyc=%0d addr=%h, want cyc=%0d addr=%h", cyc, rd_addr, e.cyc, e.addr);
                end
            end
        end
        if (frame_err) begin
            tests++;
            if (expErr.size() == 0) begin
                fails++; $display("FAIL err_unexpected cyc=%0d", cyc);
            end else begin
                int ec;
                ec = expErr.pop_front();
                if (cyc !== ec) begin
                    fails++; $display("FAIL err_event cyc=%0d, want cyc=%0d", cyc, ec);
                end
            end
        end
        if (expOut.size() > 0 && expOut[0].cyc == cyc) begin
            ob_t o;
            o = expOut.pop_front();
            tests++;
            if (vsi_outputData !== o.b) begin
                fails++; $display("FAIL out_bit cyc=%0d got=%b want=%b", cyc, vsi_outputData, o.b);
            end
        end else if (vsi_outputData !== 1'b0) begin
            tests++; fails++;
            $display("FAIL out_stray cyc=%0d got=%b want=0", cyc, vsi_outputData);
        end
    end

    // Drives cs=1 for csCycles cycles starting in the current cycle; bits beyond nBits are random.
    task automatic drive_frame(input logic op, input logic [6:0] a, input logic [127:0] d,
                               input int nBits, input int csCycles);
        logic [135:0] fr;
        fr = {op, a, d};
        for (int i = 0; i < csCycles; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            cs  = 1'b1;
            din = (i < nBits) ? fr[135-i] : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        cs = 1'b0; din = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [127:0] d, input int csCycles);
        int n;
        @(posedge clk); #1;
        n = cyc;
        expWr.push_back('{n + 136, a, d});
        drive_frame(1'b1, a, d, 136, csCycles);
        end_frame();
    endtask

    task automatic push_read(input int n, input logic [6:0] a, input logic [127:0] d, input int nOut);
        expRd.push_back('{n + 8, a, '0});
        for (int k = 0; k < nOut; k++) expOut.push_back('{n + 9 + RD_LAT + k, d[127-k]});
    endtask

    task automatic do_read(input logic [6:0] a, input logic [127:0] d);
        int n;
        @(posedge clk); #1;
        n = cyc;
        push_read(n, a, d, 128);
        drive_frame(1'b0, a, '0, 8, 137 + RD_LAT);
        end_frame();
    endtask

    task automatic test_reset();
        #2;
        tests++; if (vsi_outputData !== 1'b0) begin fails++; $display("FAIL reset_out got=%b want=0", vsi_outputData); end
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", frame_err); end
        tests++; if (wr_mask !== '0) begin fails++; $display("FAIL reset_mask got=%h want=0", wr_mask); end
        tests++; if (rd_addr !== '0) begin fails++; $display("FAIL reset_rd_addr got=%h want=0", rd_addr); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        do_write(7'h2A, W1, 136);
        repeat (4) @(posedge clk);
        tests++; if (expWr.size() !== 0) begin fails++; $display("FAIL write_missing pending=%0d want=0", expWr.size()); end
    endtask

    task automatic test_read();
        do_read(7'h2A, W1);
        repeat (4) @(posedge clk);
        tests++; if (expRd.size() !== 0) begin fails++; $display("FAIL read_rd_missing pending=%0d want=0", expRd.size()); end
        tests++; if (expOut.size() !== 0) begin fails++; $display("FAIL read_out_missing pending=%0d want=0", expOut.size()); end
    endtask

    task automatic test_abort();
        int n;
        @(posedge clk); #1;
        n = cyc;
        expErr.push_back(n + 79);
        drive_frame(1'b1, 7'h11, W2, 78, 78);
        end_frame();
        repeat (4) @(posedge clk);
        tests++; if (expErr.size() !== 0) begin fails++; $display("FAIL abort_err_missing pending=%0d want=0", expErr.size()); end
        do_read(7'h2A, W1);
        repeat (4) @(posedge clk);
        tests++; if (expOut.size() !== 0 || expRd.size() !== 0) begin
            fails++; $display("FAIL abort_next_read pending out=%0d rd=%0d want 0", expOut.size(), expRd.size());
        end
    endtask

    task automatic test_long_hold();
        do_write(7'h33, W2, 200);
        repeat (4) @(posedge clk);
        tests++; if (expWr.size() !== 0) begin fails++; $display("FAIL hold_write_missing pending=%0d want=0", expWr.size()); end
    endtask

    task automatic test_back_to_back();
        do_write(7'h00, W0, 136);
        do_write(7'h7F, W3, 136);
        do_read(7'h00, W0);
        repeat (4) @(posedge clk);
        tests++; if (expWr.size() !== 0 || expRd.size() !== 0 || expOut.size() !== 0) begin
            fails++; $display("FAIL b2b_missing pending wr=%0d rd=%0d out=%0d want 0", expWr.size(), expRd.size(), expOut.size());
        end
    endtask

    task automatic test_reset_rout();
        int n;
        @(posedge clk); #1;
        n = cyc;
        push_read(n, 7'h2A, W1, 7);
        drive_frame(1'b0, 7'h2A, '0, 8, 16 + RD_LAT);
        @(posedge clk); #1;
        tests++; if (vsi_outputData !== W1[120]) begin fails++; $display("FAIL rout_pre_reset got=%b want=%b", vsi_outputData, W1[120]); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (vsi_outputData !== 1'b0) begin fails++; $display("FAIL rout_async_out got=%b want=0", vsi_outputData); end
        tests++; if (rd_en !== 1'b0 || wr_en !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL rout_async_strobes rd=%b wr=%b err=%b want 0", rd_en, wr_en, frame_err);
        end
        cs = 1'b0; din = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        do_read(7'h7F, W3);
        repeat (4) @(posedge clk);
        tests++; if (expOut.size() !== 0 || expRd.size() !== 0) begin
            fails++; $display("FAIL rout_next_read pending out=%0d rd=%0d want 0", expOut.size(), expRd.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_long_hold();
        test_back_to_back();
        test_reset_rout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bank_serial_ctrl.md
# bank_serial_ctrl

Serial command front-end for the 128×128 two-port SRAM bank. It deserializes chip-select-framed command bits, then drives the SRAM write port (B) or read port (A), and serializes read data back out on one pin. It sits between the chip pads (vsi_inputData / vsi_chipSelect / vsi_outputData) and the SRAM macro, replacing the tied-off port connections with real traffic.

## Interface
Parameters:
- ADDR_W, 7, SRAM word address width
- DATA_W, 128, SRAM word width; also write-frame payload and read-frame length
- RD_LAT, 1, SRAM read latency in cycles from rd_en to valid rd_data (supported: 1 or 2)

Ports:
- vsi_clk  in  1  single clock; all logic on rising edge
- vsi_reset_n  in  1  asynchronous, active-low reset
- vsi_inputData  in  1  serial command/data bit, sampled while vsi_chipSelect=1
- vsi_chipSelect  in  1  frame enable; a frame is one contiguous high interval
- vsi_outputData  out  1  serial read data, registered
- wr_en  out  1  one-cycle write strobe to SRAM port B
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- wr_mask  out  DATA_W  per-bit write enable (all ones on write, zero otherwise)
- rd_en  out  1  one-cycle read strobe to SRAM port A
- rd_addr  out  ADDR_W  read address
- rd_data  in  DATA_W  SRAM read data, valid RD_LAT cycles after rd_en
- frame_err  out  1  one-cycle pulse when a frame is aborted

## Operation
- Reset: state IDLE; all outputs 0; shift registers and bit counter cleared.
- Frame format, sampled one bit per cycle while chipSelect=1: bit 0 = op (1 write, 0 read); bits 1..7 = address, MSB first; write frames add bits 8..135 = data, D[127] first.
- States: IDLE, HDR, WDATA, WRITE, RREQ, RWAIT, ROUT, DONE.
- IDLE: chipSelect=1 → sample bit 0 and go to HDR (counter=1).
- HDR: sample bits 1..7. After bit 7: op=1 → WDATA, op=0 → RREQ.
- WDATA: shift in 128 bits; after the 128th → WRITE.
- WRITE: wr_en=1, wr_mask=all ones, wr_addr/wr_data = captured values, for exactly one cycle → DONE.
- RREQ: rd_en=1, rd_addr = captured address, for one cycle → RWAIT. RWAIT lasts RD_LAT cycles and captures rd_data into the output shift register on its last cycle → ROUT.
- ROUT: vsi_outputData = Q[127] first, one bit per cycle, 128 cycles → DONE. Input bits are ignored during RREQ/RWAIT/ROUT.
- DONE: ignore input; chipSelect=0 → IDLE. Extra bits after a complete frame never trigger a second access.
- Abort: chipSelect=0 in HDR, WDATA, RREQ, RWAIT or ROUT → IDLE next cycle, frame_err pulse, no wr_en, vsi_outputData forced 0. An rd_en already issued is not retracted, but its data is discarded.
- chipSelect=0 in WRITE: the write still completes; no error.
- Every new frame requires chipSelect=0 for at least one cycle. Counter width is 8 bits and never wraps within a frame.

## Timing
- Cycle n = first cycle of chipSelect=1.
- Write: last data bit at n+135; wr_en high at n+136 only.
- Read: rd_en high at n+8; rd_data sampled at n+8+RD_LAT; vsi_outputData = Q[127] at n+9+RD_LAT through Q[0] at n+136+RD_LAT; 0 outside the read window.
- frame_err high the cycle after chipSelect falls mid-frame.
- Async reset mid-frame: outputs go to 0 immediately. After deassertion the block waits in IDLE; if chipSelect is already 1, that cycle counts as bit 0.

## Test plan
- Write frame op=1, addr=0x2A, data=0x0123…CDEF (128 b) → single wr_en at n+136, wr_addr=0x2A, wr_data matches, wr_mask=all ones; frame_err stays 0.
- Read frame op=0, addr=0x2A, model returns the same word (RD_LAT=1) → rd_en at n+8 with rd_addr=0x2A; vsi_outputData reproduces the word MSB first on cycles n+10..n+137.
- Write frame with chipSelect dropped after 70 data bits → no wr_en; frame_err pulse; the next valid read frame works.
- chipSelect held 200 cycles on a write frame with random extra bits → exactly one wr_en; no further activity until chipSelect goes low.
- Back-to-back frames (write addr 0x7F, 1 idle cycle, read addr 0x00), with RD_LAT=2 on a second build → correct strobes; output shifted by one cycle.
- Reset asserted during ROUT → vsi_outputData=0 asynchronously; state IDLE; the next frame is decoded correctly.
